// File: rtl/conv_pkg.sv
// Shared definitions for the convolve sequencer and its datapath bench:
// state encoding, frame-geometry formulas and counter sizing.
package conv_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DP_RST = 3'd1;
    localparam logic [2:0] ST_LOAD_K = 3'd2;
    localparam logic [2:0] ST_LOAD_I = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DP_RST = ST_DP_RST,
        LOAD_K = ST_LOAD_K,
        LOAD_I = ST_LOAD_I,
        DRAIN  = ST_DRAIN,
        FIN    = ST_FIN
    } ctrl_state_t;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    function automatic int kernel_words(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

    // Valid (non-padded) convolution outputs for one frame.
    function automatic int expected_outputs(input int img_length, input int img_size,
                                            input int kernel_size);
        return (img_length - kernel_size + 1) * (img_size / img_length - kernel_size + 1);
    endfunction

endpackage

// File: rtl/convolve_ctrl_if.sv
// Upstream word stream into the sequencer and the forwarded result stream out of it.
interface convolve_ctrl_if #(
    parameter int BITS = 9
);
    logic [BITS-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] out_data;
    logic            out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/conv_beat_counter.sv
// Enable/clear counter that saturates at TERMINAL, so it never wraps within a frame.
module conv_beat_counter #(
    parameter int WIDTH    = 9,
    parameter int TERMINAL = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Count register: cleared by reset or frame start, holds at the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= {WIDTH{1'b0}};
        end else if (en && (count != TERM)) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/convolve_ctrl.sv
// Sequencer for the convolve datapath: loads kernel then pixels, forwards and counts outputs.
// Optional CONVOLVE_CTRL_PERF_EN adds a busy-cycle counter on perf_cycles.
module convolve_ctrl
    import conv_pkg::*;
#(
    parameter int BITS         = 9,
    parameter int KERNEL_SIZE  = 3,
    parameter int IMG_LENGTH   = 16,
    parameter int IMG_SIZE     = 256,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    convolve_ctrl_if.slave    bus,
    output logic              dp_reset,
    output logic [BITS-1:0]   dp_kernel_in,
    output logic [BITS-1:0]   dp_img_input,
    output logic              dp_kernel_we,
    output logic              dp_shift_we,
    input  logic              dp_out_valid,
    input  logic [BITS-1:0]   dp_img_output,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       perf_cycles
);
    localparam int CW       = count_width(IMG_SIZE);
    localparam int KW       = kernel_words(KERNEL_SIZE);
    localparam int EXPECTED = expected_outputs(IMG_LENGTH, IMG_SIZE, KERNEL_SIZE);

    localparam logic [CW-1:0] K_LAST = CW'(KW - 1);
    localparam logic [CW-1:0] I_LAST = CW'(IMG_SIZE - 1);
    localparam logic [CW-1:0] O_LAST = CW'(EXPECTED - 1);
    localparam logic [CW-1:0] O_FULL = CW'(EXPECTED);
    localparam logic [CW-1:0] D_LAST = CW'(DRAIN_CYCLES - 1);

    ctrl_state_t   state_r, state_s;
    logic [CW-1:0] kcnt_r, icnt_r, ocnt_r, dcnt_r;
    logic          err_r;
    logic          frame_start_s, fwd_s, ocnt_full_s, out_valid_s, out_last_s, overflow_s;
    logic          in_ready_s, kernel_we_s, shift_we_s, drain_exit_s;

    assign frame_start_s = (state_r == IDLE) && start;
    assign fwd_s         = (state_r == LOAD_I) || (state_r == DRAIN);
    assign ocnt_full_s   = (ocnt_r == O_FULL);
    assign out_valid_s   = dp_out_valid && fwd_s && !ocnt_full_s;
    assign out_last_s    = out_valid_s && (ocnt_r == O_LAST);
    assign overflow_s    = dp_out_valid && fwd_s && ocnt_full_s;

    conv_beat_counter #(.WIDTH(CW), .TERMINAL(KW)) u_kcnt (
        .clk(clk), .reset(reset), .clear(frame_start_s),
        .en(kernel_we_s), .count(kcnt_r));
    conv_beat_counter #(.WIDTH(CW), .TERMINAL(IMG_SIZE)) u_icnt (
        .clk(clk), .reset(reset), .clear(frame_start_s),
        .en(shift_we_s), .count(icnt_r));
    conv_beat_counter #(.WIDTH(CW), .TERMINAL(EXPECTED)) u_ocnt (
        .clk(clk), .reset(reset), .clear(frame_start_s),
        .en(out_valid_s), .count(ocnt_r));
    conv_beat_counter #(.WIDTH(CW), .TERMINAL(DRAIN_CYCLES)) u_dcnt (
        .clk(clk), .reset(reset), .clear(frame_start_s),
        .en(state_r == DRAIN), .count(dcnt_r));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state stream/datapath strobes.
    always_comb begin
        state_s      = state_r;
        in_ready_s   = 1'b0;
        kernel_we_s  = 1'b0;
        shift_we_s   = 1'b0;
        drain_exit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) state_s = DP_RST;
                else       state_s = IDLE;
            end
            DP_RST: state_s = LOAD_K;
            LOAD_K: begin
                in_ready_s  = 1'b1;
                kernel_we_s = bus.in_valid;
                if (bus.in_valid && (kcnt_r == K_LAST)) state_s = LOAD_I;
                else                                     state_s = LOAD_K;
            end
            LOAD_I: begin
                in_ready_s = 1'b1;
                shift_we_s = bus.in_valid;
                if (bus.in_valid && (icnt_r == I_LAST)) state_s = DRAIN;
                else                                     state_s = LOAD_I;
            end
            DRAIN: begin
                // Leave as soon as the final beat lands, or when the datapath runs out of time.
                drain_exit_s = ocnt_full_s || out_last_s || (dcnt_r == D_LAST);
                if (drain_exit_s) state_s = FIN;
                else              state_s = DRAIN;
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sticky error: cleared on frame start, set on overflow or a short frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (frame_start_s) begin
            err_r <= 1'b0;
        end else if (overflow_s || (drain_exit_s && !(ocnt_full_s || out_last_s))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

`ifdef CONVOLVE_CTRL_PERF_EN
    logic [31:0] perf_r;

    // Busy-cycle counter, restarted by each frame and frozen once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_r <= 32'd0;
        end else if (frame_start_s) begin
            perf_r <= 32'd0;
        end else if (state_r != IDLE) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end
    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 32'd0;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = dp_img_output;
    assign dp_kernel_in  = bus.in_data;
    assign dp_img_input  = bus.in_data;
    assign dp_kernel_we  = kernel_we_s;
    assign dp_shift_we   = shift_we_s;
    assign dp_reset      = reset | (state_r == DP_RST);
    assign busy          = (state_r != IDLE);
    assign done          = (state_r == FIN);
    assign err           = err_r;
endmodule

// File: tb/tb_convolve_ctrl.sv
// Scoreboard bench for convolve_ctrl with an identity-kernel datapath model (one cycle latency).
module tb_convolve_ctrl;
    localparam int BITS = 9;
    localparam int KS   = 3;
    localparam int IL   = 16;
    localparam int IS   = 256;
    localparam int DC   = 8;
    localparam int EXP  = 196;

    logic clk;
    logic reset, start, inject;
    logic dp_reset, dp_kernel_we, dp_shift_we, dp_out_valid, busy, done, err;
    logic [BITS-1:0] dp_kernel_in, dp_img_input, dp_img_output;
    logic [31:0] perf_cycles;

    convolve_ctrl_if #(.BITS(BITS)) bus ();

    convolve_ctrl #(.BITS(BITS), .KERNEL_SIZE(KS), .IMG_LENGTH(IL), .IMG_SIZE(IS),
                    .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .dp_reset(dp_reset), .dp_kernel_in(dp_kernel_in), .dp_img_input(dp_img_input),
        .dp_kernel_we(dp_kernel_we), .dp_shift_we(dp_shift_we),
        .dp_out_valid(dp_out_valid), .dp_img_output(dp_img_output),
        .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [BITS-1:0] exp_q[$];
    int pushed, exp_emitted, stop_after;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Datapath model: stores kernel and pixels, emits centre pixel of each full 3x3 window.
    logic [BITS-1:0] img_mem [0:IS-1];
    logic [BITS-1:0] kern_mem [0:8];
    int pix_cnt, kern_cnt, emitted;
    always @(posedge clk) begin
        if (reset || dp_reset) begin
            dp_out_valid <= 1'b0;
            pix_cnt      <= 0;
            kern_cnt     <= 0;
            emitted      <= 0;
        end else begin
            dp_out_valid <= 1'b0;
            if (dp_kernel_we && kern_cnt < 9) begin
                kern_mem[kern_cnt] <= dp_kernel_in;
                kern_cnt           <= kern_cnt + 1;
            end
            if (dp_shift_we) begin
                img_mem[pix_cnt] <= dp_img_input;
                pix_cnt          <= pix_cnt + 1;
                if (pix_cnt / IL >= KS - 1 && pix_cnt % IL >= KS - 1 && emitted < stop_after) begin
                    dp_out_valid  <= 1'b1;
                    dp_img_output <= img_mem[pix_cnt - IL - 1];
                    emitted       <= emitted + 1;
                end
            end else if (inject) begin
                dp_out_valid  <= 1'b1;
                dp_img_output <= 9'h1AA;
                emitted       <= emitted + 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every forwarded beat and tallies frame events.
    int beats = 0, dp_beats = 0, dones = 0, busy_cycles = 0, viol = 0;
    logic err_at_done = 1'b0;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            beats <= beats + 1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra_beat: got data %0d with no expected beat queued", bus.out_data);
            end else begin
                check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
        if (dp_out_valid === 1'b1) dp_beats <= dp_beats + 1;
        if (done === 1'b1) begin
            dones       <= dones + 1;
            err_at_done <= err;
        end
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
        if ((dp_shift_we === 1'b1 && bus.in_valid !== 1'b1) ||
            (dp_kernel_we === 1'b1 && bus.in_valid !== 1'b1) ||
            (dp_kernel_we === 1'b1 && dp_shift_we === 1'b1)) viol <= viol + 1;
    end

    task automatic expect_beat(input logic [BITS-1:0] v);
        if (exp_emitted < stop_after) begin
            exp_emitted++;
            if (pushed < EXP) begin
                exp_q.push_back(v);
                pushed++;
            end
        end
    endtask

    task automatic send(input logic [BITS-1:0] d);
        int waitc = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input bit toggle, input int stop_n,
                             input int inject_at, input int abort_at,
                             input logic exp_err, input int exp_busy);
        int beats0, dp0, dones0, busy0, viol0, waitc;
        exp_q.delete();
        pushed = 0;
        exp_emitted = 0;
        stop_after = stop_n;
        beats0 = beats; dp0 = dp_beats; dones0 = dones; busy0 = busy_cycles; viol0 = viol;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < KS * KS; k++) begin
            send((k == 4) ? 9'd1 : 9'd0);
            if (toggle) idle1();
        end
        for (int p = 0; p < IS; p++) begin
            send(BITS'(p));
            if (p / IL >= KS - 1 && p % IL >= KS - 1) expect_beat(BITS'(p - IL - 1));
            if (p == inject_at) begin
                bus.in_valid = 1'b0;
                inject = 1'b1;
                @(posedge clk);
                #1;
                inject = 1'b0;
                expect_beat(9'h1AA);
            end else if (toggle) begin
                idle1();
            end
            if (p + 1 == abort_at) begin
                bus.in_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                check({tag, "_dp_reset_in_reset"}, 32'(dp_reset), 32'd1);
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                check({tag, "_busy_after_reset"}, 32'(busy), 32'd0);
                repeat (3) @(negedge clk);
                check({tag, "_no_done"}, 32'(dones - dones0), 32'd0);
                check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
                return;
            end
        end
        bus.in_valid = 1'b0;
        waitc = 0;
        while (dones == dones0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(dones - dones0), 32'd1);
        check({tag, "_err_at_done"}, 32'(err_at_done), 32'(exp_err));
        check({tag, "_err_held"}, 32'(err), 32'(exp_err));
        check({tag, "_out_beats"}, 32'(beats - beats0), 32'(pushed));
        check({tag, "_dp_beats"}, 32'(dp_beats - dp0), 32'(exp_emitted));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_strobe_violations"}, 32'(viol - viol0), 32'd0);
        check({tag, "_kernel_centre"}, 32'(kern_mem[4]), 32'd1);
        check({tag, "_kernel_words"}, 32'(kern_cnt), 32'd9);
        if (exp_busy > 0) check({tag, "_busy_cycles"}, 32'(busy_cycles - busy0), 32'(exp_busy));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        inject = 1'b0;
        stop_after = 1000;
        bus.in_valid = 1'b0;
        bus.in_data = 9'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_dp_reset", 32'(dp_reset), 32'd1);
        check("rst_perf", perf_cycles, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_dp_reset", 32'(dp_reset), 32'd0);
        @(posedge clk);
        #1;

        run_frame("t1_stream", 1'b0, 1000, -1, -1, 1'b0, 268);
`ifdef CONVOLVE_CTRL_PERF_EN
        check("t1_perf", perf_cycles, 32'd268);
`else
        check("t1_perf", perf_cycles, 32'd0);
`endif
        run_frame("t2_toggle", 1'b1, 1000, -1, -1, 1'b0, -1);
        run_frame("t3_timeout", 1'b0, 190, -1, -1, 1'b1, 275);
`ifdef CONVOLVE_CTRL_PERF_EN
        check("t3_perf", perf_cycles, 32'd275);
`else
        check("t3_perf", perf_cycles, 32'd0);
`endif
        run_frame("t4_overflow", 1'b0, 1000, 50, -1, 1'b1, 269);
        run_frame("t5_abort", 1'b0, 1000, -1, 100, 1'b0, -1);
        run_frame("t5_clean", 1'b0, 1000, -1, -1, 1'b0, 268);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
